aes_serial_master: RTL and testbench
====================================

# aes_serial_master

Host-side sequencer that drives the byte-serial, 5-bit-addressed register interface of the `aes_top` core. It accepts a 128-bit block, a 128-bit key and a direction flag over a valid/ready handshake, then writes 32 bytes, starts the core, waits for completion and reads back 16 bytes. It returns the 128-bit result over a second valid/ready handshake. It sits between a processor/UART front end and `aes_top` on the ZYBO Z7-10.

## Interface
Parameters:
- `RD_LAT`, default 1: cycles from driving `core_addr` to sampling `core_data_out`. Range is 1–3.
- `TIMEOUT`, default 4096: maximum number of cycles in WAIT_DONE before the operation aborts.

Ports:
- `clk`  in  1  single system clock. All logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  the request fields below are valid.
- `req_ready`  out  1  the block can accept a request. High only in IDLE.
- `req_block`  in  128  plaintext or ciphertext. Byte i is `[127-8i -: 8]`.
- `req_key`  in  128  key, with the same byte ordering as `req_block`.
- `req_decrypt`  in  1  selects decryption when 1, encryption when 0.
- `req_key_same`  in  1  key is unchanged since the last successful operation, so key writes are skipped.
- `rsp_valid`  out  1  the result is valid.
- `rsp_ready`  in  1  the consumer accepts the result.
- `rsp_data`  out  128  result. Byte i is `[127-8i -: 8]`.
- `rsp_error`  out  1  the operation timed out. `rsp_data` is 0 when this is set.
- `core_data_in`  out  8  write byte to `aes_top`.
- `core_addr`  out  5  register address. 0–15 is data, 16–31 is key.
- `core_wr_en`  out  1  byte write strobe.
- `core_start`  out  1  start level to `aes_top`.
- `core_decrypt`  out  1  direction to `aes_top`.
- `core_data_out`  in  8  read byte from `aes_top`.
- `core_done`  in  1  operation complete, level signal.

## Operation
- **States:** IDLE, WR_BLK, WR_KEY, START, WAIT_DONE, RD, RESP, RELEASE.
- **IDLE:**
  - Moves on `req_valid && req_ready`.
  - Latches all request fields and sets byte counter = 0.
  - Goes to WR_BLK.
- **WR_BLK:**
  - One byte per cycle: `core_wr_en`=1, `core_addr`=i, `core_data_in`=block byte i.
  - After i=15, goes to START if `key_same` is set, otherwise to WR_KEY.
- **WR_KEY:**
  - Same as WR_BLK, with `core_addr`=16+i and key byte i.
  - After i=15, goes to START.
- **START:**
  - `core_start` and `core_decrypt` are driven and held until RELEASE.
  - Goes to WAIT_DONE after one cycle.
- **WAIT_DONE:**
  - Waits for a rising edge of `core_done`, detected against a registered copy `done_q`.
  - On the edge, goes to RD with counter = 0.
  - If the timeout counter reaches `TIMEOUT`-1: set `rsp_error`=1, set `rsp_data`=0, go to RESP.
- **RD:**
  - For each i = 0..15, `core_addr`=i is held for `RD_LAT`+1 cycles.
  - The byte is captured into `rsp_data[127-8i -: 8]` at the last edge of that window.
  - After i=15, goes to RESP.
- **RESP:**
  - `rsp_valid`=1, with data and error stable.
  - On `rsp_ready`, goes to RELEASE.
- **RELEASE:**
  - `core_start`=0.
  - Waits for `core_done`=0, then goes to IDLE.
- A key-less start (`key_same`=1) is legal only after a successful, non-error operation. The block tracks this in an internal `key_loaded` flag. If the flag is clear, `key_same` is ignored and key writes are performed.
- A timeout clears `key_loaded`.

## Timing
- **Reset values:** every output is 0 except `req_ready`=1 (IDLE). Counters are 0 and `key_loaded`=0.
- **Reset mid-operation:** everything returns to the reset values immediately and asynchronously. `core_start` and `core_wr_en` drop without a completion cycle.
- **Latency from request accept to `rsp_valid`** = 1 + 16 + (16 if keys are written) + 1 + D + 16·(RD_LAT+1) + 1.
  - D is the number of WAIT_DONE cycles.
  - With RD_LAT=1 and keys written, this is 67 + D.
- **Write cycles:** `core_wr_en` is high on exactly 16 or 32 consecutive cycles. Address and data are registered outputs that change together with the strobe.
- **Response hold:** `rsp_valid` stays high with stable `rsp_data` until `rsp_ready` is sampled high. A simultaneous `rsp_ready` on the first `rsp_valid` cycle is accepted in that cycle.
- **Counter widths:** the byte counter is 4 bits and ends exactly at 15 with no wrap into the key range. The timeout counter is `$clog2(TIMEOUT)` bits and saturates.
- **`core_done` high before START:** if `core_done` is already high when START is entered (stale), no edge is seen until it falls and rises again.
- **`req_valid` outside IDLE:** ignored, since `req_ready`=0.

## Structure
- **Shared package `aes_ser_pkg`:**
  - state enum
  - `BLK_BASE`=5'd0, `KEY_BASE`=5'd16, `NBYTES`=16
  - address width = 5
- **Modules:** a single module, with no sub-module. The edge detector and counters are inline.

## Test plan
- **Encrypt.** Bench: `aes_serial_master` wired to `aes_top`.
  - Stimulus: block 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, decrypt=0.
  - Required: `rsp_data`=69c4e0d86a7b0430d8cdb78070b4c55a, `rsp_error`=0.
  - Required: exactly 32 `core_wr_en` cycles, at addresses 0–31 in order.
- **Decrypt with key reuse.** Back-to-back decrypt of 69c4e0d86a7b0430d8cdb78070b4c55a with `key_same`=1.
  - Required: only 16 writes, to addresses 0–15.
  - Required: `rsp_data`=00112233445566778899aabbccddeeff.
- **Key reuse after reset.** `key_same`=1 directly after reset.
  - Required: 32 writes anyway, and a correct ciphertext.
- **Timeout.** Stub core that never raises `core_done`, with TIMEOUT=64.
  - Required: `rsp_valid` with `rsp_error`=1 and `rsp_data`=0, 64 cycles after WAIT_DONE is entered.
  - Required: the next `key_same`=1 request still writes the key.
- **Backpressure.** `rsp_ready` held low for 20 cycles.
  - Required: `rsp_valid` and `rsp_data` stable throughout.
  - Required: `core_start` stays 1 until the cycle after acceptance.
- **Reset mid-write.** `rst_n` pulsed low in WR_KEY at byte 5.
  - Required: all outputs are 0 and `req_ready`=1 within the same cycle.
  - Required: a new encrypt then passes.

Source files
------------

// File: rtl/aes_ser_pkg.sv
// Shared types and constants for the byte-serial aes_top sequencer.
package aes_ser_pkg;
    localparam int ADDR_W = 5;
    localparam int NBYTES = 16;
    localparam logic [ADDR_W-1:0] BLK_BASE = 5'd0;
    localparam logic [ADDR_W-1:0] KEY_BASE = 5'd16;

    typedef enum logic [2:0] {
        IDLE, WR_BLK, WR_KEY, START, WAIT_DONE, RD, RESP, RELEASE
    } state_e;

    // Byte i of a 128-bit word is the i-th byte from the MSB end.
    function automatic logic [7:0] byte_of(input logic [127:0] v, input logic [3:0] i);
        logic [6:0] idx;
        idx = {4'd15 - i, 3'd0};
        return v[idx +: 8];
    endfunction
endpackage

// File: rtl/aes_serial_master.sv
// Sequencer that loads block/key into aes_top byte by byte, starts it,
// waits for done and reads the 16-byte result back.
module aes_serial_master
    import aes_ser_pkg::*;
#(
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [127:0]      req_block,
    input  logic [127:0]      req_key,
    input  logic              req_decrypt,
    input  logic              req_key_same,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [127:0]      rsp_data,
    output logic              rsp_error,
    output logic [7:0]        core_data_in,
    output logic [ADDR_W-1:0] core_addr,
    output logic              core_wr_en,
    output logic              core_start,
    output logic              core_decrypt,
    input  logic [7:0]        core_data_out,
    input  logic              core_done
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [3:0] LAST = 4'(NBYTES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        lat_q, lat_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              done_q;
    logic              key_loaded_q, key_loaded_d;
    logic [127:0]      blk_q, blk_d, key_q, key_d;
    logic              dec_q, dec_d, ks_q, ks_d;
    logic [127:0]      rsp_data_q, rsp_data_d;
    logic              rsp_error_q, rsp_error_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              wr_q, wr_d, start_q, start_d, cdec_q, cdec_d;
    logic              done_rise;

    assign done_rise = core_done & ~done_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_d        = lat_q;
        tmo_d        = tmo_q;
        key_loaded_d = key_loaded_q;
        blk_d        = blk_q;
        key_d        = key_q;
        dec_d        = dec_q;
        ks_d         = ks_q;
        rsp_data_d   = rsp_data_q;
        rsp_error_d  = rsp_error_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d     = WR_BLK;
                cnt_d       = 4'd0;
                blk_d       = req_block;
                key_d       = req_key;
                dec_d       = req_decrypt;
                ks_d        = req_key_same;
                rsp_data_d  = '0;
                rsp_error_d = 1'b0;
            end
            WR_BLK: if (cnt_q == LAST) begin
                cnt_d   = 4'd0;
                state_d = (ks_q && key_loaded_q) ? START : WR_KEY;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
            WR_KEY: if (cnt_q == LAST) begin
                cnt_d   = 4'd0;
                state_d = START;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
            START: begin
                state_d = WAIT_DONE;
                tmo_d   = '0;
            end
            WAIT_DONE: if (done_rise) begin
                state_d = RD;
                cnt_d   = 4'd0;
                lat_d   = 2'd0;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_d      = RESP;
                rsp_error_d  = 1'b1;
                rsp_data_d   = '0;
                key_loaded_d = 1'b0;
            end else if (tmo_q != '1) begin
                tmo_d = tmo_q + TW'(1);
            end
            // Address is held RD_LAT+1 cycles; capture on the window's last edge.
            RD: if (lat_q == 2'(RD_LAT)) begin
                lat_d = 2'd0;
                rsp_data_d[{4'd15 - cnt_q, 3'd0} +: 8] = core_data_out;
                if (cnt_q == LAST) begin
                    state_d      = RESP;
                    key_loaded_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                lat_d = lat_q + 2'd1;
            end
            RESP:    if (rsp_ready) state_d = RELEASE;
            RELEASE: if (!core_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Core-side outputs are registered from the next state so they line up with it.
        wr_d    = (state_d == WR_BLK) || (state_d == WR_KEY);
        addr_d  = '0;
        wdata_d = 8'd0;
        if (state_d == WR_BLK) begin
            addr_d  = BLK_BASE + {1'b0, cnt_d};
            wdata_d = byte_of(blk_d, cnt_d);
        end else if (state_d == WR_KEY) begin
            addr_d  = KEY_BASE + {1'b0, cnt_d};
            wdata_d = byte_of(key_d, cnt_d);
        end else if (state_d == RD) begin
            addr_d  = BLK_BASE + {1'b0, cnt_d};
        end
        start_d = (state_d == START) || (state_d == WAIT_DONE) ||
                  (state_d == RD) || (state_d == RESP);
        cdec_d  = start_d & dec_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lat_q        <= '0;
            tmo_q        <= '0;
            done_q       <= 1'b0;
            key_loaded_q <= 1'b0;
            blk_q        <= '0;
            key_q        <= '0;
            dec_q        <= 1'b0;
            ks_q         <= 1'b0;
            rsp_data_q   <= '0;
            rsp_error_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            start_q      <= 1'b0;
            cdec_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_q        <= lat_d;
            tmo_q        <= tmo_d;
            done_q       <= core_done;
            key_loaded_q <= key_loaded_d;
            blk_q        <= blk_d;
            key_q        <= key_d;
            dec_q        <= dec_d;
            ks_q         <= ks_d;
            rsp_data_q   <= rsp_data_d;
            rsp_error_q  <= rsp_error_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            start_q      <= start_d;
            cdec_q       <= cdec_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign rsp_data     = rsp_data_q;
    assign rsp_error    = rsp_error_q;
    assign core_data_in = wdata_q;
    assign core_addr    = addr_q;
    assign core_wr_en   = wr_q;
    assign core_start   = start_q;
    assign core_decrypt = cdec_q;
endmodule

// File: tb/tb_aes_serial_master.sv
// Bench for aes_serial_master against a behavioural register-file core with a
// reversible byte-wise stand-in cipher and a request-level reference model.
module tb_aes_serial_master;
    localparam int TMO = 64;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_decrypt = 1'b0, req_key_same = 1'b0, rsp_ready = 1'b0;
    logic [127:0] req_block = '0, req_key = '0;
    logic req_ready, rsp_valid, rsp_error, core_wr_en, core_start, core_decrypt;
    logic [127:0] rsp_data;
    logic [7:0] core_data_in;
    logic [4:0] core_addr;
    logic [7:0] core_data_out = 8'd0;
    logic core_done = 1'b0;

    int checks = 0, errors = 0, cyc = 0;

    aes_serial_master #(.RD_LAT(1), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_block(req_block),
        .req_key(req_key), .req_decrypt(req_decrypt), .req_key_same(req_key_same),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .core_data_in(core_data_in), .core_addr(core_addr),
        .core_wr_en(core_wr_en), .core_start(core_start), .core_decrypt(core_decrypt),
        .core_data_out(core_data_out), .core_done(core_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in cipher: encrypt = (d^k)+1, decrypt = (d-1)^k, per byte.
    function automatic logic [7:0] xf(input logic [7:0] d, input logic [7:0] k, input bit dec);
        return dec ? ((d - 8'd1) ^ k) : ((d ^ k) + 8'd1);
    endfunction

    // Core model: 32-byte register file, done some cycles after start rises,
    // done drops with start, one-cycle registered read.
    logic [7:0] regs [32];
    logic [7:0] res [16];
    bit started = 0, stub_never = 0;
    int dcnt = 0, done_delay = 4;
    always @(posedge clk) begin
        if (core_wr_en) regs[core_addr] <= core_data_in;
        core_data_out <= res[core_addr[3:0]];
        if (!core_start) begin
            started   <= 0;
            core_done <= 1'b0;
        end else if (!started) begin
            started <= 1;
            dcnt    <= done_delay;
        end else if (!core_done && !stub_never) begin
            if (dcnt == 0) begin
                core_done <= 1'b1;
                for (int i = 0; i < 16; i++) res[i] <= xf(regs[i], regs[16+i], core_decrypt);
            end else dcnt <= dcnt - 1;
        end
    end

    logic [4:0] log_addr[$];
    logic [7:0] log_data[$];
    int log_cyc[$];
    always @(negedge clk) if (rst_n && core_wr_en) begin
        log_addr.push_back(core_addr);
        log_data.push_back(core_data_in);
        log_cyc.push_back(cyc);
    end

    // Reference model: which key the core ends up using, and what the host sees.
    logic [127:0] m_key = '0;
    bit m_loaded = 0;
    function automatic void ref_op(input logic [127:0] blk, input logic [127:0] key,
                                   input bit dec, input bit ks,
                                   output logic [127:0] exp, output bit eerr, output int nw);
        bit wk;
        wk = !(ks && m_loaded);
        if (wk) m_key = key;
        nw = wk ? 32 : 16;
        exp = '0;
        if (stub_never) begin
            eerr = 1; m_loaded = 0;
        end else begin
            eerr = 0; m_loaded = 1;
            for (int i = 0; i < 16; i++) exp[127-8*i -: 8] = xf(blk[127-8*i -: 8], m_key[127-8*i -: 8], dec);
        end
    endfunction

    // Number of logged writes that break address order, data, or adjacency.
    function automatic int wr_bad(input logic [127:0] blk, input logic [127:0] key);
        int b = 0;
        logic [7:0] ed;
        for (int i = 0; i < log_addr.size(); i++) begin
            ed = (i < 16) ? blk[127-8*i -: 8] : key[127-8*(i-16) -: 8];
            if (log_addr[i] !== 5'(i) || log_data[i] !== ed || log_cyc[i] != log_cyc[0] + i) b++;
        end
        return b;
    endfunction

    task automatic do_op(input logic [127:0] blk, input logic [127:0] key, input bit dec, input bit ks,
                         input int hold, output logic [127:0] rsp, output bit err, output bit tmo,
                         output int lat, output int unstable, output bit st_acc, output bit st_after);
        int n, scyc;
        tmo = 0; unstable = 0; scyc = -1;
        done_delay = $urandom_range(0, 12);
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 300) begin @(negedge clk); n++; end
        if (!req_ready) tmo = 1;
        log_addr.delete(); log_data.delete(); log_cyc.delete();
        req_block = blk; req_key = key; req_decrypt = dec; req_key_same = ks; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 3000) begin
            if (core_start && scyc < 0) scyc = cyc;
            @(negedge clk); n++;
        end
        if (!rsp_valid) tmo = 1;
        lat = cyc - scyc;
        rsp = rsp_data; err = rsp_error;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== rsp || rsp_error !== err || !core_start) unstable++;
        end
        st_acc = core_start;
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        st_after = core_start;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++;
        if ({rsp_valid, rsp_error, rsp_data, core_data_in, core_addr, core_wr_en, core_start, core_decrypt} !== '0) begin
            errors++; $display("FAIL reset_outputs got v=%b e=%b d=%h a=%h we=%b st=%b want all 0",
                               rsp_valid, rsp_error, rsp_data, core_addr, core_wr_en, core_start);
        end
    endtask

    task automatic test_key_same_after_reset();
        logic [127:0] k, r, er; bit e, ee, to, sa, sf; int l, u, nw;
        k = {$urandom, $urandom, $urandom, $urandom};
        ref_op(PT, k, 0, 1, er, ee, nw);
        do_op(PT, k, 0, 1, 0, r, e, to, l, u, sa, sf);
        checks++; if (to) begin errors++; $display("FAIL ksreset_handshake got timeout want response"); end
        checks++; if (r !== er) begin errors++; $display("FAIL ksreset_data got %h want %h", r, er); end
        checks++; if (log_addr.size() != nw) begin errors++; $display("FAIL ksreset_nwrites got %0d want %0d", log_addr.size(), nw); end
        checks++; if (wr_bad(PT, k) != 0) begin errors++; $display("FAIL ksreset_wrseq got %0d bad want 0", wr_bad(PT, k)); end
    endtask

    task automatic test_encrypt();
        logic [127:0] r, er; bit e, ee, to, sa, sf; int l, u, nw;
        ref_op(PT, KEY, 0, 0, er, ee, nw);
        do_op(PT, KEY, 0, 0, 0, r, e, to, l, u, sa, sf);
        checks++; if (to) begin errors++; $display("FAIL enc_handshake got timeout want response"); end
        checks++; if (r !== er || e !== 1'b0) begin errors++; $display("FAIL enc_data got %h/%b want %h/0", r, e, er); end
        checks++; if (log_addr.size() != 32) begin errors++; $display("FAIL enc_nwrites got %0d want 32", log_addr.size()); end
        checks++; if (wr_bad(PT, KEY) != 0) begin errors++; $display("FAIL enc_wrseq got %0d bad want 0", wr_bad(PT, KEY)); end
    endtask

    task automatic test_decrypt_reuse();
        logic [127:0] ct, junk, r, er; bit e, ee, to, sa, sf; int l, u, nw;
        ref_op(PT, KEY, 0, 1, ct, ee, nw);
        do_op(PT, KEY, 0, 1, 0, ct, e, to, l, u, sa, sf);
        junk = {$urandom, $urandom, $urandom, $urandom};
        ref_op(ct, junk, 1, 1, er, ee, nw);
        do_op(ct, junk, 1, 1, 0, r, e, to, l, u, sa, sf);
        checks++; if (r !== PT) begin errors++; $display("FAIL dec_roundtrip got %h want %h", r, PT); end
        checks++; if (r !== er) begin errors++; $display("FAIL dec_data got %h want %h", r, er); end
        checks++; if (log_addr.size() != 16) begin errors++; $display("FAIL dec_nwrites got %0d want 16", log_addr.size()); end
        checks++; if (wr_bad(ct, junk) != 0) begin errors++; $display("FAIL dec_wrseq got %0d bad want 0", wr_bad(ct, junk)); end
    endtask

    task automatic test_random();
        logic [127:0] b, k, r, er; bit d, ks, e, ee, to, sa, sf; int l, u, nw;
        for (int it = 0; it < 8; it++) begin
            b = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            d = 1'($urandom_range(0, 1)); ks = 1'($urandom_range(0, 1));
            ref_op(b, k, d, ks, er, ee, nw);
            do_op(b, k, d, ks, $urandom_range(0, 3), r, e, to, l, u, sa, sf);
            checks++; if (r !== er || e !== ee || to) begin errors++; $display("FAIL rand%0d_data got %h/%b want %h/%b", it, r, e, er, ee); end
            checks++; if (log_addr.size() != nw) begin errors++; $display("FAIL rand%0d_nwrites got %0d want %0d", it, log_addr.size(), nw); end
            checks++; if (wr_bad(b, k) != 0) begin errors++; $display("FAIL rand%0d_wrseq got %0d bad want 0", it, wr_bad(b, k)); end
        end
    endtask

    task automatic test_timeout();
        logic [127:0] k, r, er; bit e, ee, to, sa, sf; int l, u, nw;
        stub_never = 1;
        ref_op(PT, KEY, 0, 1, er, ee, nw);
        do_op(PT, KEY, 0, 1, 0, r, e, to, l, u, sa, sf);
        stub_never = 0;
        checks++; if (to) begin errors++; $display("FAIL tmo_handshake got no response want response"); end
        checks++; if (e !== 1'b1 || r !== '0) begin errors++; $display("FAIL tmo_result got err=%b data=%h want 1/0", e, r); end
        // START cycle plus TIMEOUT cycles of WAIT_DONE before RESP.
        checks++; if (l != TMO + 1) begin errors++; $display("FAIL tmo_latency got %0d want %0d", l, TMO + 1); end
        k = {$urandom, $urandom, $urandom, $urandom};
        ref_op(PT, k, 0, 1, er, ee, nw);
        do_op(PT, k, 0, 1, 0, r, e, to, l, u, sa, sf);
        checks++; if (log_addr.size() != 32) begin errors++; $display("FAIL tmo_rekey_nwrites got %0d want 32", log_addr.size()); end
        checks++; if (r !== er || e !== 1'b0) begin errors++; $display("FAIL tmo_rekey_data got %h/%b want %h/0", r, e, er); end
    endtask

    task automatic test_backpressure();
        logic [127:0] b, r, er; bit e, ee, to, sa, sf; int l, u, nw;
        b = {$urandom, $urandom, $urandom, $urandom};
        ref_op(b, KEY, 1, 1, er, ee, nw);
        do_op(b, KEY, 1, 1, 20, r, e, to, l, u, sa, sf);
        checks++; if (u != 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles want 0", u); end
        checks++; if (r !== er) begin errors++; $display("FAIL bp_data got %h want %h", r, er); end
        checks++; if (sa !== 1'b1 || sf !== 1'b0) begin errors++; $display("FAIL bp_start got accept=%b after=%b want 1/0", sa, sf); end
    endtask

    task automatic test_reset_mid_write();
        logic [127:0] k, r, er; bit e, ee, to, sa, sf; int l, u, nw, n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 300) begin @(negedge clk); n++; end
        req_block = PT; req_key = KEY; req_decrypt = 0; req_key_same = 0; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(core_wr_en && core_addr == 5'd21) && n < 100) begin @(negedge clk); n++; end
        checks++; if (!(core_wr_en && core_addr == 5'd21)) begin errors++; $display("FAIL rstmid_reach got addr=%0d we=%b want 21/1", core_addr, core_wr_en); end
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_req_ready got %b want 1", req_ready); end
        checks++;
        if ({rsp_valid, rsp_error, rsp_data, core_data_in, core_addr, core_wr_en, core_start, core_decrypt} !== '0) begin
            errors++; $display("FAIL rstmid_outputs got we=%b a=%h d=%h st=%b want all 0", core_wr_en, core_addr, core_data_in, core_start);
        end
        m_loaded = 0;
        @(negedge clk); rst_n = 1'b1;
        k = {$urandom, $urandom, $urandom, $urandom};
        ref_op(PT, k, 0, 1, er, ee, nw);
        do_op(PT, k, 0, 1, 0, r, e, to, l, u, sa, sf);
        checks++; if (r !== er || e !== 1'b0 || to) begin errors++; $display("FAIL rstmid_enc got %h/%b want %h/0", r, e, er); end
        checks++; if (log_addr.size() != 32) begin errors++; $display("FAIL rstmid_nwrites got %0d want 32", log_addr.size()); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 8'd0;
        for (int i = 0; i < 16; i++) res[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1 test_reset();
        @(negedge clk) rst_n = 1'b1;
        test_key_same_after_reset();
        test_encrypt();
        test_decrypt_reuse();
        test_random();
        test_timeout();
        test_backpressure();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
